write_fifo_multi: RTL and testbench
===================================

Name: write_fifo_multi

Overview:
- Parametrised successor of the single-channel write-side FIFO feeder.
- Accepts a line stream from a compute/internal write source and steers a configured number of lines into one of NUM_CHANNELS FIFO/BRAM write ports, or distributes them round-robin across all channels.
- Adds an op_done/op_error status, a line counter, and rejection of bad configurations.
- Sits between the internal write interface and the fifobram write ports of a multi-channel memory unit.

Parameters:
- DATA_WIDTH, 512, width of one line (bits).
- NUM_CHANNELS, 4, number of downstream FIFO write ports; 1..256.
- CH_W, $clog2(NUM_CHANNELS) (min 1), channel index width (derived, localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- op_start  in  1  one-cycle start pulse.
- configreg  in  32  [31:16] line count L; [15] mode (0 direct, 1 round-robin); [7:0] channel select S (direct mode only).
- in_we  in  1  source line valid.
- in_wdata  in  DATA_WIDTH  source line.
- in_almostfull  out  1  backpressure to source, combinational.
- fifo_we  out  NUM_CHANNELS  one-hot write enables, registered.
- fifo_wdata  out  DATA_WIDTH  shared write data, registered.
- fifo_almostfull  in  NUM_CHANNELS  per-channel almost-full.
- busy  out  1  high in STATE_RECV.
- op_done  out  1  one-cycle completion pulse.
- op_error  out  1  one-cycle pulse, coincident with op_done, on rejected config.
- num_written  out  16  lines written in current/last operation.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; fifo_we=0; busy=0; op_done=0; op_error=0; num_written=0; rr_ptr=0. Applies mid-operation: the operation is abandoned and no further writes occur.
- fifo_wdata <= in_wdata every cycle (not gated). fifo_we defaults to 0 each cycle. op_done and op_error default to 0.
- STATE_IDLE:
  - op_start latches L, mode and S; clears num_written and rr_ptr.
  - Direct mode with S >= NUM_CHANNELS: stay IDLE; op_done=1 and op_error=1 next cycle.
  - L==0: stay IDLE; op_done=1 next cycle, no error.
  - Otherwise go to STATE_RECV.
  - in_we while IDLE is ignored; no write.
- STATE_RECV:
  - op_start is ignored.
  - On in_we with num_written < L:
    - Direct mode: fifo_we[S] <= 1.
    - Round-robin mode: fifo_we[rr_ptr] <= 1, then rr_ptr wraps to 0 after NUM_CHANNELS-1.
    - num_written increments.
  - When num_written == L-1 on an accepted line: the write for that line and op_done are registered in the same cycle; state returns to IDLE.
- Latency: in_we at cycle n gives fifo_we/fifo_wdata at cycle n+1.
- in_almostfull:
  - Direct mode in STATE_RECV: fifo_almostfull[S].
  - Otherwise (IDLE, or round-robin mode): OR of all fifo_almostfull bits.
  - The block does not itself gate in_we on almostfull; the source is required to respect it.
- Width rules: L is 16 bits unsigned, max 65535. num_written is 16 bits and holds its value after done until the next op_start or reset.
- Simultaneous op_start and in_we in IDLE: the line is not written; counting starts next cycle.

Optional Feature:
- Macro WRITE_FIFO_MULTI_DROP_COUNT_EN.
- Defined:
  - Extra output dropped_count (16 bits).
  - Increments, saturating at 0xFFFF, on every in_we that is not written: in IDLE, or in STATE_RECV when num_written >= L.
  - Cleared by reset only.
- Undefined: port and logic absent; dropped lines are silently ignored.

Test Plan:
- Direct: NUM_CHANNELS=4, configreg L=3, mode 0, S=2; three in_we lines A,B,C → fifo_we=4'b0100 on 3 cycles with data A,B,C one cycle delayed; op_done on 3rd write; num_written=3; busy low after.
- Round-robin: L=6, mode 1; six lines D0..D5 → fifo_we sequence 0001,0010,0100,1000,0001,0010; op_done with D5.
- Boundaries: L=0 → op_done pulse the cycle after op_start, no fifo_we, op_error=0. Direct mode with S=5 (NUM_CHANNELS=4) → op_done=op_error=1, no writes.
- Backpressure: direct S=1, fifo_almostfull=4'b0010 → in_almostfull=1; fifo_almostfull=4'b0100 → in_almostfull=0. In round-robin mode, any bit set → in_almostfull=1.
- Reset mid-op: L=10, after 4 lines drive reset=0 for one cycle → busy=0, num_written=0, fifo_we=0; subsequent in_we produce no writes.
- Macro enabled: 2 lines in IDLE plus 1 extra line after L=1 completes → dropped_count=3.

Source files
------------

// File: rtl/write_fifo_multi_if.sv
// Line-stream and FIFO write-port bundle for write_fifo_multi.
// slave is the feeder's view; master is the source/FIFO side that drives it.
interface write_fifo_multi_if #(
  parameter int DATA_WIDTH   = 512,
  parameter int NUM_CHANNELS = 4
);
  logic                    in_we;
  logic [DATA_WIDTH-1:0]   in_wdata;
  logic                    in_almostfull;
  logic [NUM_CHANNELS-1:0] fifo_we;
  logic [DATA_WIDTH-1:0]   fifo_wdata;
  logic [NUM_CHANNELS-1:0] fifo_almostfull;

  modport master (
    output in_we, in_wdata, fifo_almostfull,
    input  in_almostfull, fifo_we, fifo_wdata
  );

  modport slave (
    input  in_we, in_wdata, fifo_almostfull,
    output in_almostfull, fifo_we, fifo_wdata
  );
endinterface

// File: rtl/write_fifo_multi.sv
// Multi-channel FIFO write feeder: steers L lines to one channel or round-robin.
// Optional macro WRITE_FIFO_MULTI_DROP_COUNT_EN adds a saturating dropped_count output.
module write_fifo_multi #(
  parameter int DATA_WIDTH   = 512,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      op_start,
  input  logic [31:0]               configreg,
  write_fifo_multi_if.slave         bus,
  output logic                      busy,
  output logic                      op_done,
  output logic                      op_error,
  output logic [15:0]               num_written
`ifdef WRITE_FIFO_MULTI_DROP_COUNT_EN
  ,
  output logic [15:0]               dropped_count
`endif
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [8:0] NUM_CH_9 = 9'(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic {
    STATE_IDLE,
    STATE_RECV
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic                    rr_mode_q, rr_mode_d;
  logic [CH_W-1:0]         sel_q, sel_d;
  logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [15:0]             num_written_d;
  logic [NUM_CHANNELS-1:0] fifo_we_d;
  logic                    op_done_d;
  logic                    op_error_d;
  logic                    accept;

  logic unused_cfg;
  assign unused_cfg = ^configreg[14:8];

  assign accept = bus.in_we && (state_q == STATE_RECV) && (num_written < len_q);
  assign busy   = (state_q == STATE_RECV);

  // Direct mode watches only the target channel once an operation is running.
  assign bus.in_almostfull = (state_q == STATE_RECV && !rr_mode_q)
                             ? bus.fifo_almostfull[sel_q]
                             : |bus.fifo_almostfull;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    rr_mode_d     = rr_mode_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    num_written_d = num_written;
    fifo_we_d     = '0;
    op_done_d     = 1'b0;
    op_error_d    = 1'b0;

    unique case (state_q)
      STATE_IDLE: begin
        if (op_start) begin
          len_d         = configreg[31:16];
          rr_mode_d     = configreg[15];
          sel_d         = configreg[CH_W-1:0];
          num_written_d = '0;
          rr_ptr_d      = '0;
          if (!configreg[15] && ({1'b0, configreg[7:0]} >= NUM_CH_9)) begin
            op_done_d  = 1'b1;
            op_error_d = 1'b1;
          end else if (configreg[31:16] == 16'd0) begin
            op_done_d = 1'b1;
          end else begin
            state_d = STATE_RECV;
          end
        end
      end

      STATE_RECV: begin
        if (accept) begin
          if (rr_mode_q) begin
            fifo_we_d[rr_ptr_q] = 1'b1;
            rr_ptr_d = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + 1'b1;
          end else begin
            fifo_we_d[sel_q] = 1'b1;
          end
          num_written_d = num_written + 16'd1;
          if (num_written == len_q - 16'd1) begin
            op_done_d = 1'b1;
            state_d   = STATE_IDLE;
          end
        end
      end

      default: state_d = STATE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= STATE_IDLE;
      len_q       <= '0;
      rr_mode_q   <= 1'b0;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      num_written <= '0;
      bus.fifo_we <= '0;
      op_done     <= 1'b0;
      op_error    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rr_mode_q   <= rr_mode_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      num_written <= num_written_d;
      bus.fifo_we <= fifo_we_d;
      op_done     <= op_done_d;
      op_error    <= op_error_d;
    end
  end

  // NOTE: the data path is not reset; fifo_we qualifies it, so a reset here
  // would only add fanout on the wide bus.
  always_ff @(posedge clk) begin
    bus.fifo_wdata <= bus.in_wdata;
  end

`ifdef WRITE_FIFO_MULTI_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      dropped_count <= '0;
    end else if (bus.in_we && !accept && dropped_count != 16'hFFFF) begin
      dropped_count <= dropped_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_write_fifo_multi.sv
// Scoreboard bench for write_fifo_multi: stimulus queues expected writes and
// completions, a negedge monitor pops and compares whenever the DUT emits them.
module tb_write_fifo_multi;
  localparam int DW  = 512;
  localparam int NCH = 4;

  typedef struct {
    logic [NCH-1:0] we;
    logic [DW-1:0]  data;
  } wr_t;

  typedef struct {
    logic        err;
    logic [15:0] nw;
  } done_t;

  logic        clk;
  logic        reset;
  logic        op_start;
  logic [31:0] configreg;
  logic        busy;
  logic        op_done;
  logic        op_error;
  logic [15:0] num_written;
`ifdef WRITE_FIFO_MULTI_DROP_COUNT_EN
  logic [15:0] dropped_count;
`endif

  int checks   = 0;
  int failures = 0;

  wr_t   wr_q[$];
  done_t done_q[$];

  write_fifo_multi_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) bus ();

  write_fifo_multi #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_start    (op_start),
    .configreg   (configreg),
    .bus         (bus),
    .busy        (busy),
    .op_done     (op_done),
    .op_error    (op_error),
    .num_written (num_written)
`ifdef WRITE_FIFO_MULTI_DROP_COUNT_EN
    ,
    .dropped_count (dropped_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hCAFE_0000 + 32'(i);
    return {16{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] l, input logic m, input logic [7:0] s);
    op_start  = 1'b1;
    configreg = {l, m, 7'b0, s};
    tick();
    op_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bus.in_we    = 1'b1;
    bus.in_wdata = d;
    tick();
    bus.in_we = 1'b0;
  endtask

  task automatic expect_wr(input logic [NCH-1:0] we, input logic [DW-1:0] d);
    wr_t w;
    w.we   = we;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic expect_done(input logic err, input logic [15:0] nw);
    done_t e;
    e.err = err;
    e.nw  = nw;
    done_q.push_back(e);
  endtask

  // Monitor: compares every emitted write and completion against the queues.
  always @(negedge clk) begin
    if (bus.fifo_we != '0) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", DW'(bus.fifo_we), '0);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr_enable", DW'(bus.fifo_we), DW'(w.we));
        check("wr_data", bus.fifo_wdata, w.data);
      end
    end
    if (op_done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", DW'(op_done), '0);
      end else begin
        done_t e;
        e = done_q.pop_front();
        check("done_error", DW'(op_error), DW'(e.err));
        check("done_count", DW'(num_written), DW'(e.nw));
      end
    end else if (op_error) begin
      check("error_without_done", DW'(op_error), '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset               = 1'b0;
    op_start            = 1'b0;
    configreg           = '0;
    bus.in_we           = 1'b0;
    bus.in_wdata        = '0;
    bus.fifo_almostfull = '0;
    tick();
    tick();
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(op_done), '0);
    check("rst_error", DW'(op_error), '0);
    check("rst_we", DW'(bus.fifo_we), '0);
    check("rst_count", DW'(num_written), '0);
    reset = 1'b1;
    tick();

    // Direct mode, L=3, S=2.
    start_op(16'd3, 1'b0, 8'd2);
    check("direct_busy", DW'(busy), DW'(1));
    for (int i = 0; i < 3; i++) begin
      expect_wr(4'b0100, pat(i));
      if (i == 2) expect_done(1'b0, 16'd3);
      send(pat(i));
    end
    check("direct_busy_after", DW'(busy), '0);
    check("direct_count", DW'(num_written), DW'(3));

    // Backpressure selection.
    bus.fifo_almostfull = 4'b0100;
    #1 check("af_idle_or", DW'(bus.in_almostfull), DW'(1));
    start_op(16'd1, 1'b0, 8'd1);
    bus.fifo_almostfull = 4'b0010;
    #1 check("af_direct_sel", DW'(bus.in_almostfull), DW'(1));
    bus.fifo_almostfull = 4'b0100;
    #1 check("af_direct_other", DW'(bus.in_almostfull), '0);
    bus.fifo_almostfull = '0;
    expect_wr(4'b0010, pat(10));
    expect_done(1'b0, 16'd1);
    send(pat(10));

    // Round-robin, L=6; the line coincident with op_start is dropped.
    bus.in_we    = 1'b1;
    bus.in_wdata = pat(99);
    start_op(16'd6, 1'b1, 8'd0);
    bus.in_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expect_wr(4'(1 << (i % 4)), pat(20 + i));
      if (i == 5) expect_done(1'b0, 16'd6);
      if (i == 2) begin
        bus.fifo_almostfull = 4'b1000;
        #1 check("af_rr_any", DW'(bus.in_almostfull), DW'(1));
        bus.fifo_almostfull = '0;
      end
      send(pat(20 + i));
    end
    check("rr_busy_after", DW'(busy), '0);

    // L=0: immediate done without error.
    expect_done(1'b0, 16'd0);
    start_op(16'd0, 1'b0, 8'd0);
    check("l0_done", DW'(op_done), DW'(1));
    check("l0_error", DW'(op_error), '0);
    check("l0_busy", DW'(busy), '0);

    // Direct select out of range.
    expect_done(1'b1, 16'd0);
    start_op(16'd4, 1'b0, 8'd5);
    check("bad_sel_done", DW'(op_done), DW'(1));
    check("bad_sel_error", DW'(op_error), DW'(1));
    check("bad_sel_busy", DW'(busy), '0);
    send(pat(50));

    // Reset mid-operation.
    start_op(16'd10, 1'b0, 8'd3);
    for (int i = 0; i < 4; i++) begin
      expect_wr(4'b1000, pat(60 + i));
      send(pat(60 + i));
    end
    reset = 1'b0;
    tick();
    check("mid_rst_busy", DW'(busy), '0);
    check("mid_rst_count", DW'(num_written), '0);
    check("mid_rst_we", DW'(bus.fifo_we), '0);
    reset = 1'b1;
    send(pat(64));
    send(pat(65));

`ifdef WRITE_FIFO_MULTI_DROP_COUNT_EN
    start_op(16'd1, 1'b0, 8'd0);
    expect_wr(4'b0001, pat(70));
    expect_done(1'b0, 16'd1);
    send(pat(70));
    send(pat(71));
    tick();
    check("dropped_count", DW'(dropped_count), DW'(3));
`endif

    for (int i = 0; i < 20 && (wr_q.size() != 0 || done_q.size() != 0); i++) tick();
    tick();
    check("wr_queue_drained", DW'(wr_q.size()), '0);
    check("done_queue_drained", DW'(done_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
